// File: rtl/spi_tx_ili9341_pkg.sv
// Shared types and constants for the ILI9341 SPI output path.
// Imported by the byte transmitter and its clock-divider tick.
package pkg_ili9341;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } spi_tx_state_t;

    localparam int unsigned SPI_CLK_DIV = 4;
    localparam int unsigned SPI_DW      = 8;

    localparam logic HIGH    = 1'b1;
    localparam logic LOW     = 1'b0;
    localparam logic NO_DATA = 1'b0;

endpackage

// File: rtl/spi_tx_ili9341_clk_tick.sv
// SCK half-period divider: emits a one-cycle tick every CLK_DIV cycles while
// enabled, restarting from zero whenever the enable rises.
module spi_clk_tick
    import pkg_ili9341::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic en_i,
    output logic tick_o
);

    localparam int unsigned   CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          at_last;

    assign at_last = (cnt_q == LAST);

    // Held at zero while disabled so the first enabled cycle counts as 0.
    always_comb begin
        cnt_d = cnt_q;
        if (!en_i || at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = en_i && at_last;

endmodule

// File: rtl/spi_tx_ili9341.sv
// Byte-level SPI mode-0 transmitter toward the ILI9341 panel, MSB first.
// Latches one word plus DC/CS on send and pulses command_sent when it is out.
module spi_tx_ili9341
    import pkg_ili9341::*;
#(
    parameter int unsigned DW      = SPI_DW,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_send,
    input  logic [DW-1:0] i_data,
    input  logic          i_dc,
    input  logic          i_cs,
    output logic          o_command_sent,
    output logic          o_busy,
    output logic          o_sck,
    output logic          o_mosi,
    output logic          o_dc,
    output logic          o_cs
);

    localparam int unsigned   EW        = $clog2(2 * DW + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DW - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("spi_tx_ili9341: CLK_DIV must be >= 1");
        end
        if (DW < 2) begin : g_bad_dw
            $error("spi_tx_ili9341: DW must be >= 2");
        end
    endgenerate

    spi_tx_state_t state_q, state_d;
    logic [DW-2:0] shift_q, shift_d;
    logic [EW-1:0] edge_q, edge_d;
    logic          sck_q, sck_d;
    logic          mosi_q, mosi_d;
    logic          dc_q, dc_d;
    logic          cs_q, cs_d;
    logic          busy_q, busy_d;
    logic          sent_q, sent_d;
    logic          div_en;
    logic          tick;

    assign div_en = (state_q != IDLE);

    spi_clk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_tick (
        .clk_i (clk),
        .rst_ni(rst),
        .en_i  (div_en),
        .tick_o(tick)
    );

    // Pin values are computed from the next state and registered, so every
    // output changes on the same edge as the state it belongs to.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        edge_d  = edge_q;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        dc_d    = dc_q;
        cs_d    = cs_q;

        case (state_q)
            IDLE: begin
                sck_d  = LOW;
                mosi_d = NO_DATA;
                dc_d   = HIGH;
                cs_d   = HIGH;
                edge_d = '0;
                if (i_send) begin
                    shift_d = i_data[DW-2:0];
                    mosi_d  = i_data[DW-1];
                    dc_d    = i_dc;
                    cs_d    = i_cs;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    edge_d = edge_q + EW'(1);
                    if (sck_q == LOW) begin
                        sck_d = HIGH;
                    end else begin
                        sck_d   = LOW;
                        mosi_d  = shift_q[DW-2];
                        shift_d = shift_q << 1;
                    end
                    if (edge_q == LAST_EDGE) begin
                        edge_d  = '0;
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                sck_d   = LOW;
                mosi_d  = NO_DATA;
                dc_d    = HIGH;
                cs_d    = HIGH;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        sent_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            shift_q <= '0;
            edge_q  <= '0;
            sck_q   <= LOW;
            mosi_q  <= NO_DATA;
            dc_q    <= HIGH;
            cs_q    <= HIGH;
            busy_q  <= LOW;
            sent_q  <= LOW;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            edge_q  <= edge_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            dc_q    <= dc_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            sent_q  <= sent_d;
        end
    end

    assign o_command_sent = sent_q;
    assign o_busy         = busy_q;
    assign o_sck          = sck_q;
    assign o_mosi         = mosi_q;
    assign o_dc           = dc_q;
    assign o_cs           = cs_q;

endmodule
